// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select codes match the ALU operand mux encoding.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding compare for one ALU operand.
// The EX/MEM result is newer than MEM/WB, so it wins; register 0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        sel_o
);

  logic memHit;
  logic wbHit;

  assign memHit = mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == src_i);
  assign wbHit  = wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (memHit) begin
      sel_o = FWD_EXMEM;
    end else if (wbHit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register control: load-use stalls, branch flushes, memory-wait freeze,
// EX forwarding selects and saturating stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              br_taken,
  input  logic              dmem_busy,
  input  logic              cnt_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_hold,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              stallInc;
  logic              flushInc;
  logic              runMode;
  logic              loadUse;
  logic [1:0]        fwdARaw;
  logic [1:0]        fwdBRaw;

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src_i           (ex_rs),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_i        (mem_rd),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_i         (wb_rd),
    .sel_o           (fwdARaw)
  );

  fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src_i           (ex_rt),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_i        (mem_rd),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_i         (wb_rd),
    .sel_o           (fwdBRaw)
  );

  assign loadUse = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  assign fwd_a = rst ? fwdARaw : FWD_RF;
  assign fwd_b = rst ? fwdBRaw : FWD_RF;

  // A MEM_WAIT cycle whose memory has just become ready behaves exactly like RUN,
  // so a branch held in the frozen EX stage is acted on without losing a cycle.
  always_comb begin
    state_d    = state_q;
    runMode    = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    stallInc   = 1'b0;
    flushInc   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmem_busy) begin
          state_d = MEM_WAIT;
        end else begin
          runMode = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_busy) begin
          state_d = RUN;
          runMode = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (!runMode) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      stallInc   = 1'b1;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flushInc   = 1'b1;
    end else if (loadUse) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      stallInc   = 1'b1;
    end

    if (!rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pipe_hold  = 1'b0;
      stallInc   = 1'b0;
      flushInc   = 1'b0;
      state_d    = RUN;
    end
  end

  // Counters stick at all-ones; a clear in the same cycle as an event wins.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stallInc && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
      if (flushInc && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
